pdp8l_ptr_fifo: RTL and testbench

- Buffered, parametrised PDP-8/L paper tape reader interface.
- ARM side pushes tape chars into a DEPTH-entry FIFO. The PDP-8/L side runs the reader IOPs (6xx1/2/4/6) against a holding register refilled from the FIFO on each reader step.
- Sits on the same IOP bus (iopstart/iopstop/ioopcode) and ARM register bus as the other pdp8l device blocks.
- Generalises the single-char reader with a configurable device code, FIFO depth, interrupt-enable control and an overrun status.

---
 rtl/pdp8l_ptr_fifo_pkg.sv | 31 +++
 rtl/pdp8l_ptr_fifo_if.sv | 33 +++
 rtl/pdp8l_ptr_fifo_sync_fifo.sv | 51 +++++
 rtl/pdp8l_ptr_fifo.sv | 179 +++++++++++++++++
 tb/tb_pdp8l_ptr_fifo.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pdp8l_ptr_fifo_pkg.sv
// Shared constants for the buffered PDP-8/L paper tape reader: IOP function
// codes, ARM register map and status-register bit positions.
package pdp8l_ptr_pkg;

    localparam logic [2:0] IOP_SKIP   = 3'o1;
    localparam logic [2:0] IOP_READ   = 3'o2;
    localparam logic [2:0] IOP_STEP   = 3'o4;
    localparam logic [2:0] IOP_RDSTEP = 3'o6;

    localparam logic [15:0] PTR_IDENT = 16'h5052;

    localparam int R1_RDFLAG  = 31;
    localparam int R1_ENABLE  = 30;
    localparam int R1_RDSTEP  = 29;
    localparam int R1_INTENAB = 28;
    localparam int R1_OVERRUN = 27;
    localparam int R1_FLUSH   = 26;

    typedef enum logic [1:0] {
        REG_IDENT  = 2'd0,
        REG_STATUS = 2'd1,
        REG_DATA   = 2'd2,
        REG_NONE   = 2'd3
    } arm_reg_e;

    // Occupancy and free-space fields are 8 bits wide; a 256-deep FIFO saturates.
    function automatic logic [7:0] sat8(input logic [8:0] v);
        return (v > 9'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/pdp8l_ptr_fifo_if.sv
// IOP bus and ARM register bus seen by the paper tape reader; the CPU/ARM side
// drives through the master modport, the device uses the slave modport.
interface pdp8l_ptr_fifo_if;

    logic        CSTEP;
    logic        BINIT;
    logic        armwrite;
    logic [1:0]  armraddr;
    logic [1:0]  armwaddr;
    logic [31:0] armwdata;
    logic [31:0] armrdata;
    logic        iopstart;
    logic        iopstop;
    logic [11:0] ioopcode;
    logic [11:0] cputodev;
    logic [11:0] devtocpu;
    logic        AC_CLEAR;
    logic        IO_SKIP;
    logic        INT_RQST;

    modport master (
        output CSTEP, BINIT, armwrite, armraddr, armwaddr, armwdata,
               iopstart, iopstop, ioopcode, cputodev,
        input  armrdata, devtocpu, AC_CLEAR, IO_SKIP, INT_RQST
    );

    modport slave (
        input  CSTEP, BINIT, armwrite, armraddr, armwaddr, armwdata,
               iopstart, iopstop, ioopcode, cputodev,
        output armrdata, devtocpu, AC_CLEAR, IO_SKIP, INT_RQST
    );

endinterface

// File: rtl/pdp8l_ptr_fifo_sync_fifo.sv
// 8-bit synchronous FIFO with wrap-bit pointers, flush and async reset.
// Pushes into a full FIFO and pops from an empty one are ignored.
module pdp8l_sync_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int AW = DEPTH_LOG2;

    logic [7:0]  mem [2**AW];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge CLOCK) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pdp8l_ptr_fifo.sv
// Buffered PDP-8/L paper tape reader: ARM pushes chars into a FIFO, reader IOPs
// consume them via a holding register. Define PTR_OVERRUN_EN for sticky overrun.
module pdp8l_ptr_fifo
    import pdp8l_ptr_pkg::*;
#(
    parameter logic [5:0]  DEVCODE    = 6'o01,
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [11:0] VERSION    = 12'h002
) (
    input logic              CLOCK,
    input logic              RESET,
    pdp8l_ptr_fifo_if.slave  bus
);

    localparam int            CW      = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_V = CW'(2 ** DEPTH_LOG2);

    logic        enable,   enable_n;
    logic        intenab,  intenab_n;
    logic        rdflag,   rdflag_n;
    logic        rdstep,   rdstep_n;
    logic        io_skip,  io_skip_n;
    logic [7:0]  rdchar,   rdchar_n;
    logic [11:0] devtocpu, devtocpu_n;
    logic        overrun;

    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] free_cnt;

    logic wr_status;
    logic wr_data;
    logic flush;
    logic refill;
    logic iop_hit;
    logic unused_bits;

    // BINIT suppresses every other event in its cycle, so it gates all strobes here.
    assign wr_status = ~bus.BINIT & bus.armwrite & (bus.armwaddr == REG_STATUS);
    assign wr_data   = ~bus.BINIT & bus.armwrite & (bus.armwaddr == REG_DATA);
    assign flush     = wr_status & bus.armwdata[R1_FLUSH];
    assign refill    = ~bus.BINIT & ~flush & rdstep & ~empty;
    assign iop_hit   = ~bus.BINIT & bus.CSTEP & bus.iopstart & enable
                     & (bus.ioopcode[11:3] == {3'o6, DEVCODE});

    assign free_cnt    = DEPTH_V - count;
    assign unused_bits = ^{bus.cputodev, bus.armwdata};

    pdp8l_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .push  (wr_data),
        .pop   (refill),
        .flush (flush),
        .wdata (bus.armwdata[7:0]),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // NOTE: every next-state variable takes its current value first, so no latches.
    always_comb begin
        enable_n   = enable;
        intenab_n  = intenab;
        rdflag_n   = rdflag;
        rdstep_n   = rdstep;
        io_skip_n  = io_skip;
        rdchar_n   = rdchar;
        devtocpu_n = devtocpu;

        if (bus.CSTEP && bus.iopstop) begin
            devtocpu_n = '0;
            io_skip_n  = 1'b0;
        end

        if (refill) begin
            rdchar_n = head;
            rdflag_n = 1'b1;
            rdstep_n = 1'b0;
        end

        if (iop_hit) begin
            unique case (bus.ioopcode[2:0])
                IOP_SKIP: io_skip_n = rdflag;
                IOP_READ: begin
                    devtocpu_n = {4'b0, rdchar};
                    rdflag_n   = 1'b0;
                end
                IOP_STEP: begin
                    rdflag_n = 1'b0;
                    rdstep_n = 1'b1;
                end
                IOP_RDSTEP: begin
                    devtocpu_n = {4'b0, rdchar};
                    rdflag_n   = 1'b0;
                    rdstep_n   = 1'b1;
                end
                default: ;
            endcase
        end

        if (wr_status) begin
            enable_n  = bus.armwdata[R1_ENABLE];
            intenab_n = bus.armwdata[R1_INTENAB];
        end

        // A flush discards any pending step; the CPU has to step again.
        if (flush) begin
            rdflag_n = 1'b0;
            rdstep_n = 1'b0;
        end

        if (bus.BINIT) begin
            intenab_n = 1'b1;
            rdflag_n  = 1'b0;
            rdstep_n  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            enable   <= 1'b0;
            intenab  <= 1'b1;
            rdflag   <= 1'b0;
            rdstep   <= 1'b0;
            io_skip  <= 1'b0;
            rdchar   <= '0;
            devtocpu <= '0;
        end else begin
            enable   <= enable_n;
            intenab  <= intenab_n;
            rdflag   <= rdflag_n;
            rdstep   <= rdstep_n;
            io_skip  <= io_skip_n;
            rdchar   <= rdchar_n;
            devtocpu <= devtocpu_n;
        end
    end

`ifdef PTR_OVERRUN_EN
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)
            overrun <= 1'b0;
        else if (wr_data && full)
            overrun <= 1'b1;
        else if (wr_status && bus.armwdata[R1_OVERRUN])
            overrun <= 1'b0;
    end
`else
    assign overrun = 1'b0;
`endif

    always_comb begin
        bus.armrdata = '0;
        unique case (arm_reg_e'(bus.armraddr))
            REG_IDENT: bus.armrdata = {PTR_IDENT, 4'd1, VERSION};
            REG_STATUS: begin
                bus.armrdata[R1_RDFLAG]  = rdflag;
                bus.armrdata[R1_ENABLE]  = enable;
                bus.armrdata[R1_RDSTEP]  = rdstep;
                bus.armrdata[R1_INTENAB] = intenab;
                bus.armrdata[R1_OVERRUN] = overrun;
                bus.armrdata[23:16]      = sat8(9'(count));
                bus.armrdata[7:0]        = rdchar;
            end
            REG_DATA: bus.armrdata[31:24] = sat8(9'(free_cnt));
            default:  bus.armrdata = '0;
        endcase
    end

    assign bus.devtocpu = devtocpu;
    assign bus.IO_SKIP  = io_skip;
    assign bus.AC_CLEAR = 1'b0;
    assign bus.INT_RQST = intenab & (rdflag | overrun);

endmodule

// File: tb/tb_pdp8l_ptr_fifo.sv
// Directed bench for pdp8l_ptr_fifo: main instance at DEVCODE 01, a second at
// DEVCODE 03 sharing the same bus traffic. Honours PTR_OVERRUN_EN if defined.
module tb_pdp8l_ptr_fifo;

    logic CLOCK;
    logic RESET;
    int   tests = 0;
    int   fails = 0;

    pdp8l_ptr_fifo_if bus ();
    pdp8l_ptr_fifo_if bus3 ();

    pdp8l_ptr_fifo #(.DEVCODE(6'o01), .DEPTH_LOG2(4)) u_dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    pdp8l_ptr_fifo #(.DEVCODE(6'o03), .DEPTH_LOG2(4)) u_dut3 (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus3.slave)
    );

    assign bus3.CSTEP    = bus.CSTEP;
    assign bus3.BINIT    = bus.BINIT;
    assign bus3.armwrite = bus.armwrite;
    assign bus3.armraddr = bus.armraddr;
    assign bus3.armwaddr = bus.armwaddr;
    assign bus3.armwdata = bus.armwdata;
    assign bus3.iopstart = bus.iopstart;
    assign bus3.iopstop  = bus.iopstop;
    assign bus3.ioopcode = bus.ioopcode;
    assign bus3.cputodev = bus.cputodev;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        bus.armraddr = addr;
        #1;
        check(tag, bus.armrdata, exp);
    endtask

    task automatic arm_wr(input logic [1:0] addr, input logic [31:0] data);
        bus.armwrite = 1'b1;
        bus.armwaddr = addr;
        bus.armwdata = data;
        tick();
        bus.armwrite = 1'b0;
    endtask

    task automatic iop_start(input logic [11:0] op);
        bus.CSTEP    = 1'b1;
        bus.ioopcode = op;
        bus.iopstart = 1'b1;
        tick();
        bus.iopstart = 1'b0;
    endtask

    task automatic iop_stop();
        bus.iopstop = 1'b1;
        tick();
        bus.iopstop = 1'b0;
        bus.CSTEP   = 1'b0;
    endtask

    initial begin
        RESET        = 1'b1;
        bus.CSTEP    = 1'b0;
        bus.BINIT    = 1'b0;
        bus.armwrite = 1'b0;
        bus.armraddr = 2'd0;
        bus.armwaddr = 2'd0;
        bus.armwdata = '0;
        bus.iopstart = 1'b0;
        bus.iopstop  = 1'b0;
        bus.ioopcode = '0;
        bus.cputodev = '0;
        tick();
        tick();
        RESET = 1'b0;
        tick();

        // Reset state
        chk_reg("reset_reg0", 2'd0, 32'h5052_1002);
        chk_reg("reset_reg1", 2'd1, 32'h1000_0000);
        chk_reg("reset_reg2", 2'd2, 32'h1000_0000);
        tick();
        chk_reg("reset_reg3", 2'd3, 32'h0000_0000);
        check("reset_devtocpu", 32'(bus.devtocpu), 32'h0);
        check("reset_skip", 32'(bus.IO_SKIP), 32'h0);
        check("reset_int", 32'(bus.INT_RQST), 32'h0);
        check("reset_acclr", 32'(bus.AC_CLEAR), 32'h0);

        // Enable (intenab off), push two chars, step and read
        arm_wr(2'd1, 32'h4000_0000);
        arm_wr(2'd2, 32'h41);
        arm_wr(2'd2, 32'h42);
        chk_reg("push2_reg1", 2'd1, 32'h4002_0000);
        iop_start(12'o6014);
        chk_reg("step_pending", 2'd1, 32'h6002_0000);
        iop_stop();
        chk_reg("refill_0x41", 2'd1, 32'hC001_0041);
        check("int_intenab0", 32'(bus.INT_RQST), 32'h0);

        iop_start(12'o6011);
        check("skip_6011", 32'(bus.IO_SKIP), 32'h1);
        iop_stop();
        check("skip_release", 32'(bus.IO_SKIP), 32'h0);

        iop_start(12'o6012);
        check("read_6012", 32'(bus.devtocpu), 32'h041);
        chk_reg("read_clr_flag", 2'd1, 32'h4001_0041);
        iop_stop();
        check("read_release", 32'(bus.devtocpu), 32'h0);

        // Flush, then step on an empty FIFO and push late
        arm_wr(2'd1, 32'h4400_0000);
        chk_reg("flush_reg1", 2'd1, 32'h4000_0041);
        chk_reg("flush_free", 2'd2, 32'h1000_0000);
        iop_start(12'o6016);
        check("rdstep_data", 32'(bus.devtocpu), 32'h041);
        iop_stop();
        tick();
        chk_reg("rdstep_wait", 2'd1, 32'h6000_0041);
        arm_wr(2'd2, 32'h7F);
        chk_reg("late_push_1", 2'd1, 32'h6001_0041);
        tick();
        chk_reg("late_push_2", 2'd1, 32'hC000_007F);

        arm_wr(2'd1, 32'h5000_0000);
        check("int_rdflag", 32'(bus.INT_RQST), 32'h1);
        iop_start(12'o6012);
        iop_stop();
        chk_reg("read_7f", 2'd1, 32'h5000_007F);
        check("int_cleared", 32'(bus.INT_RQST), 32'h0);

        // Fill to 16 and overflow with a 17th push
        for (int i = 0; i < 16; i++) arm_wr(2'd2, 32'(i));
        chk_reg("full_reg1", 2'd1, 32'h5010_007F);
        chk_reg("full_free", 2'd2, 32'h0000_0000);
        arm_wr(2'd2, 32'h99);
`ifdef PTR_OVERRUN_EN
        chk_reg("overrun_reg1", 2'd1, 32'h5810_007F);
        check("overrun_int", 32'(bus.INT_RQST), 32'h1);
`else
        chk_reg("overrun_reg1", 2'd1, 32'h5010_007F);
        check("overrun_int", 32'(bus.INT_RQST), 32'h0);
`endif
        arm_wr(2'd1, 32'h5800_0000);
        chk_reg("overrun_clear", 2'd1, 32'h5010_007F);
        check("overrun_int_clr", 32'(bus.INT_RQST), 32'h0);

        // Drain all 16 entries in order; the 17th must not appear
        for (int i = 0; i < 16; i++) begin
            iop_start(12'o6014);
            iop_stop();
            chk_reg($sformatf("drain_%0d", i), 2'd1,
                    32'hD000_0000 | (32'(15 - i) << 16) | 32'(i));
        end
        iop_start(12'o6014);
        iop_stop();
        tick();
        chk_reg("drain_empty", 2'd1, 32'h7000_000F);
        arm_wr(2'd1, 32'h5400_0000);
        chk_reg("flush_step", 2'd1, 32'h5000_000F);

        // BINIT keeps FIFO contents and enable
        arm_wr(2'd1, 32'h4000_0000);
        arm_wr(2'd2, 32'h55);
        iop_start(12'o6014);
        iop_stop();
        arm_wr(2'd2, 32'h56);
        chk_reg("pre_binit", 2'd1, 32'hC001_0055);
        check("pre_binit_int", 32'(bus.INT_RQST), 32'h0);
        bus.BINIT = 1'b1;
        tick();
        bus.BINIT = 1'b0;
        chk_reg("post_binit", 2'd1, 32'h5001_0055);

        // Disabled device ignores IOPs; device code must match
        iop_start(12'o6014);
        iop_stop();
        chk_reg("refill_0x56", 2'd1, 32'hD000_0056);
        arm_wr(2'd1, 32'h1000_0000);
        iop_start(12'o6011);
        check("skip_disabled", 32'(bus.IO_SKIP), 32'h0);
        iop_stop();
        arm_wr(2'd1, 32'h5000_0000);
        iop_start(12'o6031);
        check("skip_wrong_dev", 32'(bus.IO_SKIP), 32'h0);
        check("dev3_skip_noflag", 32'(bus3.IO_SKIP), 32'h0);
        iop_stop();
        iop_start(12'o6011);
        check("skip_reenabled", 32'(bus.IO_SKIP), 32'h1);
        iop_stop();

        // DEVCODE 03 instance: step, skip and read its head (0x55)
        iop_start(12'o6034);
        iop_stop();
        iop_start(12'o6031);
        check("dev3_skip", 32'(bus3.IO_SKIP), 32'h1);
        check("dev1_ignores_6031", 32'(bus.IO_SKIP), 32'h0);
        iop_stop();
        iop_start(12'o6032);
        check("dev3_read", 32'(bus3.devtocpu), 32'h055);
        check("dev1_ignores_6032", 32'(bus.devtocpu), 32'h0);
        iop_stop();

        // Asynchronous reset while a refill is pending
        arm_wr(2'd2, 32'h66);
        iop_start(12'o6016);
        check("pre_reset_data", 32'(bus.devtocpu), 32'h056);
        chk_reg("pre_reset_reg1", 2'd1, 32'h7001_0056);
        #2;
        RESET        = 1'b1;
        bus.CSTEP    = 1'b0;
        #1;
        check("async_devtocpu", 32'(bus.devtocpu), 32'h0);
        check("async_skip", 32'(bus.IO_SKIP), 32'h0);
        check("async_int", 32'(bus.INT_RQST), 32'h0);
        chk_reg("async_reg1", 2'd1, 32'h1000_0000);
        chk_reg("async_free", 2'd2, 32'h1000_0000);
        tick();
        RESET = 1'b0;
        tick();
        chk_reg("after_reset", 2'd1, 32'h1000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
